// File: rtl/regbus_arbiter.sv
// regbus_arbiter: round-robin two-requester arbiter for the peripheral register bus; define REGARB_WPROT_EN to block B writes to 0x8-0xF
module regbus_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [AW-1:0] m_addr,
  output logic          m_wen,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          grant_b
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam logic [3:0] MAX_L = 4'(MAX_LOCK);
  logic [1:0] state;
  logic ptr;
  logic [3:0] lock_cnt;
  logic we_l, lock_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic sel, access, prot;
  assign sel = (a_req & b_req) ? ptr : b_req;
  assign access = state == ACCESS;
`ifdef REGARB_WPROT_EN
  assign prot = grant_b & we_l & addr_l[3];
  assign b_err = b_ack & prot;
`else
  assign prot = 1'b0;
  assign b_err = 1'b0;
`endif
  assign m_addr = access ? addr_l : '0;
  assign m_wdata = access ? wdata_l : '0;
  assign m_wen = access & we_l & rst_n & ~prot;
  assign busy = state != IDLE;
  assign a_ack = (state == RESP) & ~grant_b;
  assign b_ack = (state == RESP) & grant_b;
  // grant in IDLE, capture read data in ACCESS, rotate or hold priority in RESP
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      lock_cnt <= '0;
      grant_b <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      we_l <= 1'b0;
      lock_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
    end else
      case (state)
        IDLE:
          if (a_req | b_req) begin
            state <= ACCESS;
            grant_b <= sel;
            we_l <= sel ? b_we : a_we;
            lock_l <= sel ? b_lock : a_lock;
            addr_l <= sel ? b_addr : a_addr;
            wdata_l <= sel ? b_wdata : a_wdata;
            if (sel != grant_b) lock_cnt <= '0;
          end
        ACCESS: begin
          state <= RESP;
          if (grant_b) b_rdata <= m_rdata;
          else a_rdata <= m_rdata;
        end
        RESP: begin
          state <= IDLE;
          if (lock_l && lock_cnt < MAX_L) begin
            ptr <= grant_b;
            lock_cnt <= lock_cnt + 4'd1;
          end else begin
            ptr <= ~grant_b;
            if (!lock_l) lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: scoreboard bench for regbus_arbiter with a register-bus memory model
module tb_regbus_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic a_ack, b_ack, b_err, busy, grant_b, m_wen;
  logic [7:0] a_rdata, b_rdata, m_wdata, m_rdata;
  logic [3:0] m_addr;
  typedef struct {
    logic b;
    logic [7:0] rd;
    logic err;
  } exp_t;
  exp_t q[$];
  logic [7:0] mem [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                           8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};
  logic [7:0] exp_mem [16];
  int n_chk = 0, n_fail = 0, cyc = 0, wen_cnt = 0, last_ack = -1, w0 = 0;
  logic gap_chk = 1'b0;

  regbus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .grant_b(grant_b)
  );

  assign m_rdata = mem[m_addr];
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_wen) begin
      mem[m_addr] <= m_wdata;
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic [7:0] rd, input logic err);
    exp_t e;
    e.b = b;
    e.rd = rd;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic requester(input logic who, input int n, input logic we, input logic lock,
                           input logic [3:0] addr, input logic [7:0] wd);
    int got = 0, t = 0;
    if (who) begin
      b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
    while (got < n && t < 100) begin
      @(negedge clk);
      t++;
      if (who ? b_ack : a_ack) got++;
    end
    chk(who ? "b_ack_count" : "a_ack_count", got, n);
    @(posedge clk);
    #1;
    if (who) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_ack || b_ack) begin
      chk("ack_exclusive", {31'd0, a_ack & b_ack}, 0);
      if (q.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        e = q.pop_front();
        chk("ack_owner", {31'd0, b_ack}, {31'd0, e.b});
        chk("ack_rdata", b_ack ? b_rdata : a_rdata, e.rd);
        chk("ack_b_err", {31'd0, b_err}, {31'd0, e.err & b_ack});
      end
      if (gap_chk && last_ack >= 0) chk("ack_gap", cyc - last_ack, 3);
      last_ack = gap_chk ? cyc : -1;
    end else if (!gap_chk) last_ack = -1;
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'(8'h10 + i * 8'h11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_acks", {a_ack, b_ack, b_err}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_m_bus", {m_wen, m_addr, m_wdata}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, exp_mem[3], 0);
    exp_mem[3] = 8'hA5;
    a_we = 1'b1; a_addr = 4'h3; a_wdata = 8'hA5; a_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_busy_access", busy, 1);
    chk("t1_m_wen", m_wen, 1);
    chk("t1_m_addr", m_addr, 4'h3);
    chk("t1_m_wdata", m_wdata, 8'hA5);
    chk("t1_grant_b", grant_b, 0);
    @(negedge clk);
    chk("t1_busy_resp", busy, 1);
    chk("t1_a_ack", a_ack, 1);
    chk("t1_m_wen_resp", m_wen, 0);
    @(posedge clk);
    #1 a_req = 1'b0;
    a_we = 1'b0;
    @(negedge clk);
    chk("t1_busy_idle", busy, 0);
    chk("t1_mem", mem[3], 8'hA5);
    w0 = wen_cnt;
    push(0, 8'hA5, 0);
    requester(0, 1, 0, 0, 4'h3, 8'h00);
    chk("t2_no_write", wen_cnt - w0, 0);
    push(1, exp_mem[7], 0);
    requester(1, 1, 0, 0, 4'h7, 8'h00);
    gap_chk = 1'b1;
    push(0, exp_mem[1], 0); push(1, exp_mem[2], 0);
    push(0, exp_mem[1], 0); push(1, exp_mem[2], 0);
    fork
      requester(0, 2, 0, 0, 4'h1, 8'h00);
      requester(1, 2, 0, 0, 4'h2, 8'h00);
    join
    gap_chk = 1'b0;
    @(negedge clk);
    gap_chk = 1'b1;
    for (int i = 0; i < 5; i++) push(0, exp_mem[4], 0);
    push(1, exp_mem[6], 0);
    push(0, exp_mem[4], 0);
    fork
      requester(0, 6, 0, 1, 4'h4, 8'h00);
      requester(1, 1, 0, 0, 4'h6, 8'h00);
    join
    gap_chk = 1'b0;
    push(0, exp_mem[0], 0);
    requester(0, 1, 0, 0, 4'h0, 8'h00);
    b_we = 1'b1; b_lock = 1'b0; b_addr = 4'h5; b_wdata = 8'h3C; b_req = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    b_req = 1'b0;
    b_we = 1'b0;
    @(negedge clk);
    chk("rst_mid_m_wen", m_wen, 0);
    chk("rst_mid_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_grant_b", grant_b, 0);
    repeat (4) @(negedge clk);
    chk("rst_mem_kept", mem[5], exp_mem[5]);
    push(0, exp_mem[9], 0);
    push(1, exp_mem[10], 0);
    fork
      requester(0, 1, 0, 0, 4'h9, 8'h00);
      requester(1, 1, 0, 0, 4'hA, 8'h00);
    join
    w0 = wen_cnt;
`ifdef REGARB_WPROT_EN
    push(1, exp_mem[8], 1);
    requester(1, 1, 1, 0, 4'h8, 8'hFF);
    chk("wp_write_count", wen_cnt - w0, 0);
`else
    push(1, exp_mem[8], 0);
    exp_mem[8] = 8'hFF;
    requester(1, 1, 1, 0, 4'h8, 8'hFF);
    chk("wp_write_count", wen_cnt - w0, 1);
`endif
    chk("wp_mem", mem[8], exp_mem[8]);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
